// File: rtl/pcie_rst_seq_pkg.sv
// Shared types and defaults for the PCIe multi-stage reset sequencer.
package pcie_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    DONE      = 2'd2
  } seq_state_e;

  localparam int STAGE_DLY_LOG2_DEF = 19;
  localparam int WDOG_LOG2_DEF      = 24;

  // Stage index width; a single-stage build still needs a 1-bit index.
  function automatic int idx_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/pcie_rst_seq_sync.sv
// Single-bit synchroniser: SYNC_STAGES-deep flop chain, cleared by rstn.
module rst_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_125,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the async input into the chain, newest sample in bit 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Synchroniser flops.
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pcie_rst_seq.sv
// Multi-stage PCIe reset sequencer. Releases stage_rst_n[0..NUM_STAGES-1]
// in order, 2^STAGE_DLY_LOG2+1 cycles apart, once the synchronised PLL lock
// is present. Loss of lock or soft_rst drops every stage and restarts.
// Optional link watchdog is built when PCIE_RST_WDOG_EN is defined.
//
// state     | meaning
// WAIT_LOCK | all stages held in reset, waiting for lock_s and !soft_rst
// COUNT     | delay counter running; releases stage idx on terminal count
// DONE      | all stages released; watchdog (if built) monitors link_s
module pcie_rst_seq
  import pcie_rst_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int STAGE_DLY_LOG2 = STAGE_DLY_LOG2_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int WDOG_LOG2      = WDOG_LOG2_DEF
) (
  input  logic                  clk_125,
  input  logic                  rstn,
  input  logic                  pll_lock,
  input  logic                  soft_rst,
  input  logic                  link_up,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  wdog_trip
);

  localparam int IDX_W = idx_width(NUM_STAGES);
  localparam int CNT_W = STAGE_DLY_LOG2 + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  seq_state_e              state_d, state_q;
  logic [IDX_W-1:0]        idx_d, idx_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic [NUM_STAGES-1:0]   stage_d, stage_q;
  logic                    done_d, done_q;
  logic                    lock_s;
  logic                    abort;

  rst_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_125 (clk_125),
    .rstn    (rstn),
    .d       (pll_lock),
    .q       (lock_s)
  );

`ifdef PCIE_RST_WDOG_EN
  localparam int WCNT_W = WDOG_LOG2 + 1;
  logic              link_s;
  logic [WCNT_W-1:0] wcnt_d, wcnt_q;
  logic              wdog_d, wdog_q;

  rst_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_link_sync (
    .clk_125 (clk_125),
    .rstn    (rstn),
    .d       (link_up),
    .q       (link_s)
  );
`endif

  assign abort = !lock_s || soft_rst;

  // Next-state, stage release and watchdog decisions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    done_d  = done_q;
`ifdef PCIE_RST_WDOG_EN
    wcnt_d  = '0;
    wdog_d  = 1'b0;
`endif
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s && !soft_rst) state_d = COUNT;
      end
      COUNT: begin
        if (abort) begin
          state_d = WAIT_LOCK;
          stage_d = '0;
          done_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q[STAGE_DLY_LOG2]) begin
          // Abort is checked first, so a same-cycle release never escapes.
          stage_d = stage_q | (NUM_STAGES'(1) << idx_q);
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (abort) begin
          state_d = WAIT_LOCK;
          stage_d = '0;
          done_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end
`ifdef PCIE_RST_WDOG_EN
        else if (wcnt_q[WDOG_LOG2]) begin
          wdog_d  = 1'b1;
          state_d = WAIT_LOCK;
          stage_d = '0;
          done_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (!link_s) begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = WAIT_LOCK;
        stage_d = '0;
        done_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer registers; every output comes straight from a flop.
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT_LOCK;
      idx_q   <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

`ifdef PCIE_RST_WDOG_EN
  // Watchdog counter and trip pulse.
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      wcnt_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign wdog_trip = wdog_q;
`else
  // Without the watchdog link_up and WDOG_LOG2 have no effect; term is constant 0.
  assign wdog_trip = link_up & (WDOG_LOG2 < 0);
`endif

  assign stage_rst_n = stage_q;
  assign seq_done    = done_q;

endmodule

// File: tb/tb_pcie_rst_seq.sv
// Directed bench for pcie_rst_seq with NUM_STAGES=3, STAGE_DLY_LOG2=4,
// SYNC_STAGES=2, WDOG_LOG2=5. Stage spacing is 17 cycles; from the pll_lock
// edge, bit 0 rises after 2 sync edges + 1 edge into COUNT + 17 = 20 edges.
module tb_pcie_rst_seq;

  logic       clk_125 = 1'b0;
  logic       rstn;
  logic       pll_lock;
  logic       soft_rst;
  logic       link_up;
  logic [2:0] stage_rst_n;
  logic       seq_done;
  logic       wdog_trip;

  int errors = 0;
  int checks = 0;

  pcie_rst_seq #(
    .NUM_STAGES     (3),
    .STAGE_DLY_LOG2 (4),
    .SYNC_STAGES    (2),
    .WDOG_LOG2      (5)
  ) dut (
    .clk_125     (clk_125),
    .rstn        (rstn),
    .pll_lock    (pll_lock),
    .soft_rst    (soft_rst),
    .link_up     (link_up),
    .stage_rst_n (stage_rst_n),
    .seq_done    (seq_done),
    .wdog_trip   (wdog_trip)
  );

  always #4 clk_125 = ~clk_125;

  // Advance n rising edges, then settle on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_125);
    @(negedge clk_125);
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    pll_lock = 1'b0;
    soft_rst = 1'b0;
    link_up  = 1'b0;
    tick(3);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL reset_stage: got %b want 000", stage_rst_n); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", seq_done); end
    checks++; if (wdog_trip !== 1'b0) begin errors++; $display("FAIL reset_trip: got %b want 0", wdog_trip); end
    tick(5);
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL no_lock_hold: got %b want 000", stage_rst_n); end
  endtask

  // Leaves the DUT in DONE with stage_rst_n=111.
  task automatic test_sequence();
    apply_reset();
    pll_lock = 1'b1;
    tick(19);
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL seq_pre0: got %b want 000", stage_rst_n); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b001) begin errors++; $display("FAIL seq_bit0: got %b want 001", stage_rst_n); end
    checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL seq_done0: got %b want 0", seq_done); end
    tick(16);
    checks++; if (stage_rst_n !== 3'b001) begin errors++; $display("FAIL seq_pre1: got %b want 001", stage_rst_n); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b011) begin errors++; $display("FAIL seq_bit1: got %b want 011", stage_rst_n); end
    tick(16);
    checks++; if (seq_done !== 1'b0 || stage_rst_n !== 3'b011) begin errors++; $display("FAIL seq_pre2: got %b/%b want 011/0", stage_rst_n, seq_done); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b111) begin errors++; $display("FAIL seq_bit2: got %b want 111", stage_rst_n); end
    checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL seq_done: got %b want 1", seq_done); end
  endtask

  // Leaves the DUT in DONE with stage_rst_n=111.
  task automatic test_lock_loss();
    apply_reset();
    pll_lock = 1'b1;
    tick(37);
    checks++; if (stage_rst_n !== 3'b011) begin errors++; $display("FAIL lock_pre: got %b want 011", stage_rst_n); end
    tick(1);
    pll_lock = 1'b0;
    tick(2);
    checks++; if (stage_rst_n !== 3'b011) begin errors++; $display("FAIL lock_syncdly: got %b want 011", stage_rst_n); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b000 || seq_done !== 1'b0) begin errors++; $display("FAIL lock_abort: got %b/%b want 000/0", stage_rst_n, seq_done); end
    pll_lock = 1'b1;
    tick(19);
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL relock_pre0: got %b want 000", stage_rst_n); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b001) begin errors++; $display("FAIL relock_bit0: got %b want 001", stage_rst_n); end
    tick(17);
    checks++; if (stage_rst_n !== 3'b011) begin errors++; $display("FAIL relock_bit1: got %b want 011", stage_rst_n); end
    tick(17);
    checks++; if (stage_rst_n !== 3'b111 || seq_done !== 1'b1) begin errors++; $display("FAIL relock_done: got %b/%b want 111/1", stage_rst_n, seq_done); end
  endtask

  // Entered in DONE; leaves the DUT in DONE.
  task automatic test_soft_pulse();
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    checks++; if (stage_rst_n !== 3'b000 || seq_done !== 1'b0) begin errors++; $display("FAIL soft_abort: got %b/%b want 000/0", stage_rst_n, seq_done); end
    tick(17);
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL soft_pre0: got %b want 000", stage_rst_n); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b001) begin errors++; $display("FAIL soft_bit0: got %b want 001", stage_rst_n); end
    tick(17);
    checks++; if (stage_rst_n !== 3'b011) begin errors++; $display("FAIL soft_bit1: got %b want 011", stage_rst_n); end
    tick(17);
    checks++; if (stage_rst_n !== 3'b111 || seq_done !== 1'b1) begin errors++; $display("FAIL soft_done: got %b/%b want 111/1", stage_rst_n, seq_done); end
  endtask

  // Entered in DONE; soft_rst held 6 edges keeps everything in reset.
  task automatic test_soft_hold();
    int bad;
    bad = 0;
    soft_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (stage_rst_n !== 3'b000 || seq_done !== 1'b0) bad++;
    end
    soft_rst = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL soft_hold: %0d cycles not 000, want 0", bad); end
    tick(17);
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL hold_pre0: got %b want 000", stage_rst_n); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b001) begin errors++; $display("FAIL hold_bit0: got %b want 001", stage_rst_n); end
    tick(34);
    checks++; if (stage_rst_n !== 3'b111) begin errors++; $display("FAIL hold_done: got %b want 111", stage_rst_n); end
  endtask

  // Entered in DONE; soft_rst lands on the terminal cycle of stage 2.
  task automatic test_terminal_abort();
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    tick(35);
    checks++; if (stage_rst_n !== 3'b011) begin errors++; $display("FAIL term_pre: got %b want 011", stage_rst_n); end
    tick(16);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    checks++; if (stage_rst_n !== 3'b000 || seq_done !== 1'b0) begin errors++; $display("FAIL term_abort: got %b/%b want 000/0", stage_rst_n, seq_done); end
    tick(2);
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL term_nobit2: got %b want 000", stage_rst_n); end
  endtask

  task automatic test_rstn_mid();
    apply_reset();
    pll_lock = 1'b1;
    tick(20);
    checks++; if (stage_rst_n !== 3'b001) begin errors++; $display("FAIL rstn_pre: got %b want 001", stage_rst_n); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (stage_rst_n !== 3'b000 || seq_done !== 1'b0) begin errors++; $display("FAIL rstn_async: got %b/%b want 000/0", stage_rst_n, seq_done); end
    @(negedge clk_125);
    rstn = 1'b1;
    tick(19);
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL rstn_pre0: got %b want 000", stage_rst_n); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b001) begin errors++; $display("FAIL rstn_bit0: got %b want 001", stage_rst_n); end
    tick(34);
    checks++; if (stage_rst_n !== 3'b111) begin errors++; $display("FAIL rstn_done: got %b want 111", stage_rst_n); end
  endtask

`ifdef PCIE_RST_WDOG_EN
  // Entered on the edge that set 111 with link_up=0 throughout.
  task automatic test_wdog();
    int trips;
    tick(32);
    checks++; if (wdog_trip !== 1'b0 || stage_rst_n !== 3'b111) begin errors++; $display("FAIL wdog_early: got %b/%b want 0/111", wdog_trip, stage_rst_n); end
    tick(1);
    checks++; if (wdog_trip !== 1'b1) begin errors++; $display("FAIL wdog_trip: got %b want 1", wdog_trip); end
    checks++; if (stage_rst_n !== 3'b000 || seq_done !== 1'b0) begin errors++; $display("FAIL wdog_abort: got %b/%b want 000/0", stage_rst_n, seq_done); end
    tick(1);
    checks++; if (wdog_trip !== 1'b0) begin errors++; $display("FAIL wdog_pulse: got %b want 0", wdog_trip); end
    tick(16);
    checks++; if (stage_rst_n !== 3'b000) begin errors++; $display("FAIL wdog_pre0: got %b want 000", stage_rst_n); end
    tick(1);
    checks++; if (stage_rst_n !== 3'b001) begin errors++; $display("FAIL wdog_bit0: got %b want 001", stage_rst_n); end
    tick(34);
    checks++; if (stage_rst_n !== 3'b111) begin errors++; $display("FAIL wdog_redone: got %b want 111", stage_rst_n); end
    tick(20);
    link_up = 1'b1;
    trips = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (wdog_trip !== 1'b0) trips++;
    end
    checks++; if (trips != 0) begin errors++; $display("FAIL wdog_link_ok: %0d trips want 0", trips); end
    checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL wdog_keep: got %b want 1", seq_done); end
  endtask
`else
  // Entered in DONE: link_up stays low, nothing may trip.
  task automatic test_no_wdog();
    int trips;
    trips = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (wdog_trip !== 1'b0) trips++;
    end
    checks++; if (trips != 0) begin errors++; $display("FAIL nowdog_trip: %0d trips want 0", trips); end
    checks++; if (seq_done !== 1'b1 || stage_rst_n !== 3'b111) begin errors++; $display("FAIL nowdog_keep: got %b/%b want 111/1", stage_rst_n, seq_done); end
  endtask
`endif

  initial begin
    rstn     = 1'b0;
    pll_lock = 1'b0;
    soft_rst = 1'b0;
    link_up  = 1'b0;
    test_reset();
    test_sequence();
    test_lock_loss();
    test_soft_pulse();
    test_soft_hold();
    test_terminal_abort();
    test_rstn_mid();
`ifdef PCIE_RST_WDOG_EN
    test_wdog();
`else
    test_no_wdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
